// File: rtl/natalius_seq_ctrl_pkg.sv
// Shared encodings for the Gen-2 Natalius sequencer: opcodes, ALU/shifter codes, FSM states.
package natalius_seq_ctrl_pkg;

  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_WAIT_IO, ST_IRQ} state_t;

  localparam logic [4:0] OP_EI = 5'd0, OP_RETI = 5'd1, OP_LDI = 5'd2, OP_LDM = 5'd3,
    OP_STM = 5'd4, OP_CMP = 5'd5, OP_ADD = 5'd6, OP_SUB = 5'd7, OP_AND = 5'd8,
    OP_OOR = 5'd9, OP_XOR = 5'd10, OP_JMP = 5'd11, OP_JPZ = 5'd12, OP_JNZ = 5'd13,
    OP_JPC = 5'd14, OP_JNC = 5'd15, OP_CSR = 5'd16, OP_RET = 5'd17, OP_ADI = 5'd18,
    OP_CSZ = 5'd19, OP_CNZ = 5'd20, OP_CSC = 5'd21, OP_CNC = 5'd22, OP_SL0 = 5'd23,
    OP_SL1 = 5'd24, OP_SR0 = 5'd25, OP_SR1 = 5'd26, OP_RRL = 5'd27, OP_RRR = 5'd28,
    OP_NOT = 5'd29, OP_NOP = 5'd30, OP_LDR = 5'd31;

  localparam logic [2:0] ALU_NOT = 3'd0, ALU_AND = 3'd1, ALU_XOR = 3'd2, ALU_OR = 3'd3,
    ALU_PASS = 3'd4, ALU_ADD = 3'd5, ALU_SUB = 3'd6;

  localparam logic [2:0] SH_SL0 = 3'd0, SH_RRL = 3'd1, SH_SR0 = 3'd2, SH_RRR = 3'd3,
    SH_PASS = 3'd4, SH_SL1 = 3'd5, SH_SR1 = 3'd6;

  function automatic logic [2:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OOR:  return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

  function automatic logic [2:0] shift_code(input logic [4:0] op);
    case (op)
      OP_SL0:  return SH_SL0;
      OP_SL1:  return SH_SL1;
      OP_SR0:  return SH_SR0;
      OP_SR1:  return SH_SR1;
      OP_RRL:  return SH_RRL;
      OP_RRR:  return SH_RRR;
      default: return SH_PASS;
    endcase
  endfunction

endpackage

// File: rtl/natalius_seq_ctrl_if.sv
// Sequencer <-> datapath bundle; master is the sequencer, slave is the datapath side.
interface natalius_seq_ctrl_if #(parameter int ADDR_W = 11);
  logic [15:0]       instruction;
  logic              zero, carry;
  logic [ADDR_W-1:0] stack_addr;
  logic              stack_full, stack_empty, io_ready, irq;
  logic [7:0]        port_addr;
  logic              write_e, read_e, insel, we;
  logic [2:0]        raa, rab, wa, opalu, sh;
  logic              selpc, ldpc, ldflag;
  logic [ADDR_W-1:0] naddress;
  logic              selk, selimm;
  logic [7:0]        kte;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              selrom, flag_save, flag_restore, irq_ack, io_err, stack_err;

  modport master (
    input  instruction, zero, carry, stack_addr, stack_full, stack_empty, io_ready, irq,
    output port_addr, write_e, read_e, insel, we, raa, rab, wa, opalu, sh, selpc, ldpc,
           ldflag, naddress, selk, selimm, kte, wr_en, rd_en, rom_addr, selrom,
           flag_save, flag_restore, irq_ack, io_err, stack_err
  );

  modport slave (
    output instruction, zero, carry, stack_addr, stack_full, stack_empty, io_ready, irq,
    input  port_addr, write_e, read_e, insel, we, raa, rab, wa, opalu, sh, selpc, ldpc,
           ldflag, naddress, selk, selimm, kte, wr_en, rd_en, rom_addr, selrom,
           flag_save, flag_restore, irq_ack, io_err, stack_err
  );
endinterface

// File: rtl/natalius_seq_ctrl_io_timer.sv
// I/O wait-state counter; flags the wait cycle on which the limit is reached (limit 0 = never).
module natalius_seq_ctrl_io_timer #(
  parameter int IO_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic timeout
);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || !active || ready) count <= '0;
    else                         count <= count + CNT_W'(1);
  end

  assign timeout = (IO_TIMEOUT != 0) && active && !ready && (count == LAST);
endmodule

// File: rtl/natalius_seq_ctrl.sv
// Gen-2 Natalius sequencer: fetch/decode/execute FSM with interrupts, I/O wait-states,
// ROM-data reads and stack fault protection.
module natalius_seq_ctrl
  import natalius_seq_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 11,
  parameter logic [ADDR_W-1:0] IRQ_VEC    = 'h004,
  parameter int                IO_TIMEOUT = 16,
  parameter logic [ADDR_W-9:0] LDR_PAGE   = 'h7
) (
  input logic clk,
  input logic rst,
  natalius_seq_ctrl_if.master bus
);
  state_t            state;
  logic              ie, ie_next, pop_ok, timeout, io_op, leave, take_irq, jmp_cond, call_cond;
  logic [4:0]        op;
  logic [2:0]        ra, rb;
  logic [7:0]        lit;
  logic [ADDR_W-1:0] target;

  assign op     = bus.instruction[15:11];
  assign ra     = bus.instruction[10:8];
  assign rb     = bus.instruction[7:5];
  assign lit    = bus.instruction[7:0];
  assign target = ADDR_W'(bus.instruction[10:0]);
  assign io_op  = (op == OP_LDM) || (op == OP_STM);

  natalius_seq_ctrl_io_timer #(.IO_TIMEOUT(IO_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .active(state == ST_WAIT_IO), .ready(bus.io_ready), .timeout(timeout)
  );

  always_comb begin
    jmp_cond  = 1'b0;
    call_cond = 1'b0;
    case (op)
      OP_JMP, OP_CSR: begin jmp_cond = 1'b1;         call_cond = 1'b1;         end
      OP_JPZ, OP_CSZ: begin jmp_cond = bus.zero;     call_cond = bus.zero;     end
      OP_JNZ, OP_CNZ: begin jmp_cond = !bus.zero;    call_cond = !bus.zero;    end
      OP_JPC, OP_CSC: begin jmp_cond = bus.carry;    call_cond = bus.carry;    end
      OP_JNC, OP_CNC: begin jmp_cond = !bus.carry;   call_cond = !bus.carry;   end
      default: ;
    endcase
  end

  // An ie write in this EXEC must be visible to the interrupt check in the same cycle
  always_comb begin
    ie_next = ie;
    if (state == ST_EXEC) begin
      if (op == OP_EI)                 ie_next = bus.instruction[0];
      else if (op == OP_RETI && pop_ok) ie_next = 1'b1;
    end
  end

  assign leave    = ((state == ST_EXEC) && !(io_op && !bus.io_ready)) ||
                    ((state == ST_WAIT_IO) && (bus.io_ready || timeout));
  assign take_irq = leave && bus.irq && ie_next && !bus.stack_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_FETCH;
      ie     <= 1'b0;
      pop_ok <= 1'b0;
    end else begin
      ie <= (state == ST_IRQ) ? 1'b0 : ie_next;
      case (state)
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          state  <= ST_EXEC;
          pop_ok <= !bus.stack_empty;
        end
        ST_EXEC, ST_WAIT_IO: begin
          if (!leave)        state <= ST_WAIT_IO;
          else if (take_irq) state <= ST_IRQ;
          else               state <= ST_FETCH;
        end
        default:   state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.port_addr = '0;  bus.write_e = 1'b0; bus.read_e = 1'b0; bus.insel = 1'b0;
    bus.we = 1'b0;       bus.raa = '0;       bus.rab = '0;      bus.wa = '0;
    bus.opalu = ALU_PASS; bus.sh = SH_PASS;  bus.selpc = 1'b0;  bus.ldpc = 1'b1;
    bus.ldflag = 1'b0;   bus.naddress = '0;  bus.selk = 1'b0;   bus.selimm = 1'b0;
    bus.kte = '0;        bus.wr_en = 1'b0;   bus.rd_en = 1'b0;  bus.rom_addr = '0;
    bus.selrom = 1'b0;   bus.flag_save = 1'b0; bus.flag_restore = 1'b0;
    bus.irq_ack = 1'b0;  bus.io_err = 1'b0;  bus.stack_err = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: bus.ldpc = 1'b0;
        ST_DECODE: begin
          bus.ldpc = 1'b0;
          if (op == OP_LDR) bus.rom_addr = {LDR_PAGE, lit};
          if (op == OP_RET || op == OP_RETI) bus.rd_en = !bus.stack_empty;
        end
        ST_EXEC: begin
          case (op)
            OP_RET, OP_RETI: begin
              if (pop_ok) begin
                bus.naddress     = bus.stack_addr;
                bus.selpc        = 1'b1;
                bus.flag_restore = (op == OP_RETI);
              end else bus.stack_err = 1'b1;
            end
            OP_LDI: begin bus.selk = 1'b1; bus.kte = lit; bus.wa = ra; bus.we = 1'b1; end
            OP_CMP: begin
              bus.raa = ra; bus.rab = rb; bus.opalu = ALU_SUB; bus.ldflag = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OOR, OP_XOR: begin
              bus.raa = ra; bus.rab = rb; bus.opalu = alu_code(op);
              bus.insel = 1'b1; bus.we = 1'b1; bus.wa = ra; bus.ldflag = 1'b1;
            end
            OP_ADI: begin
              bus.raa = ra; bus.selimm = 1'b1; bus.kte = lit; bus.opalu = ALU_ADD;
              bus.insel = 1'b1; bus.we = 1'b1; bus.wa = ra; bus.ldflag = 1'b1;
            end
            OP_NOT: begin
              bus.raa = ra; bus.opalu = ALU_NOT;
              bus.insel = 1'b1; bus.we = 1'b1; bus.wa = ra; bus.ldflag = 1'b1;
            end
            OP_SL0, OP_SL1, OP_SR0, OP_SR1, OP_RRL, OP_RRR: begin
              bus.raa = ra; bus.sh = shift_code(op); bus.insel = 1'b1; bus.we = 1'b1; bus.wa = ra;
            end
            OP_JMP, OP_JPZ, OP_JNZ, OP_JPC, OP_JNC: begin
              if (jmp_cond) begin bus.naddress = target; bus.selpc = 1'b1; end
            end
            OP_CSR, OP_CSZ, OP_CNZ, OP_CSC, OP_CNC: begin
              if (call_cond && bus.stack_full) bus.stack_err = 1'b1;
              else if (call_cond) begin
                bus.naddress = target; bus.selpc = 1'b1; bus.wr_en = 1'b1;
              end
            end
            OP_LDR: begin bus.selrom = 1'b1; bus.we = 1'b1; bus.wa = ra; end
            default: ;
          endcase
        end
        ST_IRQ: begin
          bus.wr_en = 1'b1; bus.irq_ack = 1'b1; bus.flag_save = 1'b1;
          bus.selpc = 1'b1; bus.naddress = IRQ_VEC;
        end
        default: ;
      endcase
      // I/O accesses hold address and strobe until ready or timeout
      if (io_op && (state == ST_DECODE || state == ST_EXEC || state == ST_WAIT_IO)) begin
        bus.port_addr = lit;
        bus.raa       = ra;
        bus.wa        = ra;
        if (state != ST_DECODE) begin
          bus.read_e  = (op == OP_LDM);
          bus.write_e = (op == OP_STM);
          bus.we      = (op == OP_LDM) && bus.io_ready;
          bus.ldpc    = bus.io_ready || timeout;
          bus.io_err  = timeout;
        end
      end
    end
  end
endmodule

// File: tb/tb_natalius_seq_ctrl.sv
// Randomized bench for natalius_seq_ctrl against an instruction-level reference model.
module tb_natalius_seq_ctrl;
  localparam int IO_TO = 16;

  typedef struct packed {
    logic [7:0]  port_addr;
    logic        write_e, read_e, insel, we;
    logic [2:0]  raa, rab, wa, opalu, sh;
    logic        selpc, ldpc, ldflag;
    logic [10:0] naddress;
    logic        selk, selimm;
    logic [7:0]  kte;
    logic        wr_en, rd_en;
    logic [10:0] rom_addr;
    logic        selrom, flag_save, flag_restore, irq_ack, io_err, stack_err;
  } ctl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic ie_m = 1'b0;

  natalius_seq_ctrl_if #(.ADDR_W(11)) bus();

  natalius_seq_ctrl #(.ADDR_W(11), .IRQ_VEC(11'h004), .IO_TIMEOUT(IO_TO), .LDR_PAGE(3'h7)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t s;
    s.port_addr = bus.port_addr; s.write_e = bus.write_e; s.read_e = bus.read_e;
    s.insel = bus.insel; s.we = bus.we; s.raa = bus.raa; s.rab = bus.rab; s.wa = bus.wa;
    s.opalu = bus.opalu; s.sh = bus.sh; s.selpc = bus.selpc; s.ldpc = bus.ldpc;
    s.ldflag = bus.ldflag; s.naddress = bus.naddress; s.selk = bus.selk;
    s.selimm = bus.selimm; s.kte = bus.kte; s.wr_en = bus.wr_en; s.rd_en = bus.rd_en;
    s.rom_addr = bus.rom_addr; s.selrom = bus.selrom; s.flag_save = bus.flag_save;
    s.flag_restore = bus.flag_restore; s.irq_ack = bus.irq_ack; s.io_err = bus.io_err;
    s.stack_err = bus.stack_err;
    return s;
  endfunction

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.opalu = 3'd4; c.sh = 3'd4; c.ldpc = 1'b1;
    return c;
  endfunction

  function automatic bit is_io(input logic [15:0] ins);
    return (ins[15:11] == 5'd3) || (ins[15:11] == 5'd4);
  endfunction

  function automatic ctl_t m_decode(input logic [15:0] ins, input bit empty);
    ctl_t c = idle();
    c.ldpc = 1'b0;
    case (ins[15:11])
      5'd3, 5'd4: begin c.port_addr = ins[7:0]; c.raa = ins[10:8]; c.wa = ins[10:8]; end
      5'd31:      c.rom_addr = {3'h7, ins[7:0]};
      5'd1, 5'd17: c.rd_en = !empty;
      default: ;
    endcase
    return c;
  endfunction

  // One cycle of an ldm/stm access: ready completes it, to marks the timeout cycle
  function automatic ctl_t m_io(input logic [15:0] ins, input bit ready, input bit to);
    ctl_t c = idle();
    c.port_addr = ins[7:0]; c.raa = ins[10:8]; c.wa = ins[10:8];
    c.read_e  = (ins[15:11] == 5'd3);
    c.write_e = (ins[15:11] == 5'd4);
    c.we      = c.read_e && ready;
    c.ldpc    = ready || to;
    c.io_err  = to;
    return c;
  endfunction

  function automatic ctl_t m_exec(input logic [15:0] ins, input bit z, input bit cy,
                                  input bit full, input bit empty, input logic [10:0] saddr);
    ctl_t c = idle();
    logic [4:0] op = ins[15:11];
    logic [2:0] ra = ins[10:8];
    logic [2:0] rb = ins[7:5];
    bit cond;
    case (op)
      5'd1, 5'd17: begin
        if (empty) c.stack_err = 1'b1;
        else begin c.naddress = saddr; c.selpc = 1'b1; c.flag_restore = (op == 5'd1); end
      end
      5'd2: begin c.selk = 1'b1; c.kte = ins[7:0]; c.wa = ra; c.we = 1'b1; end
      5'd5: begin c.raa = ra; c.rab = rb; c.opalu = 3'd6; c.ldflag = 1'b1; end
      5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
        c.raa = ra; c.rab = rb; c.wa = ra; c.we = 1'b1; c.insel = 1'b1; c.ldflag = 1'b1;
        c.opalu = (op == 5'd6) ? 3'd5 : (op == 5'd7) ? 3'd6 : (op == 5'd8) ? 3'd1 :
                  (op == 5'd9) ? 3'd3 : 3'd2;
      end
      5'd18: begin
        c.raa = ra; c.selimm = 1'b1; c.kte = ins[7:0]; c.opalu = 3'd5;
        c.insel = 1'b1; c.we = 1'b1; c.wa = ra; c.ldflag = 1'b1;
      end
      5'd29: begin
        c.raa = ra; c.opalu = 3'd0; c.insel = 1'b1; c.we = 1'b1; c.wa = ra; c.ldflag = 1'b1;
      end
      5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28: begin
        c.raa = ra; c.insel = 1'b1; c.we = 1'b1; c.wa = ra;
        c.sh = (op == 5'd23) ? 3'd0 : (op == 5'd24) ? 3'd5 : (op == 5'd25) ? 3'd2 :
               (op == 5'd26) ? 3'd6 : (op == 5'd27) ? 3'd1 : 3'd3;
      end
      5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin
        cond = (op == 5'd11) || (op == 5'd12 && z) || (op == 5'd13 && !z) ||
               (op == 5'd14 && cy) || (op == 5'd15 && !cy);
        if (cond) begin c.naddress = ins[10:0]; c.selpc = 1'b1; end
      end
      5'd16, 5'd19, 5'd20, 5'd21, 5'd22: begin
        cond = (op == 5'd16) || (op == 5'd19 && z) || (op == 5'd20 && !z) ||
               (op == 5'd21 && cy) || (op == 5'd22 && !cy);
        if (cond && full) c.stack_err = 1'b1;
        else if (cond) begin c.naddress = ins[10:0]; c.selpc = 1'b1; c.wr_en = 1'b1; end
      end
      5'd31: begin c.selrom = 1'b1; c.we = 1'b1; c.wa = ra; end
      default: ;
    endcase
    return c;
  endfunction

  // Runs one instruction from its FETCH cycle; rst_at>0 pulls reset on that wait cycle
  task automatic run(input logic [15:0] ins, input int nlow, input bit irq_v, input bit z,
                     input bit cy, input bit full, input bit empty, input logic [10:0] saddr,
                     input int rst_at);
    ctl_t e;
    int   w;
    bit   ready, to, done;
    string nm;
    nm = $sformatf("op%0d_%h", ins[15:11], ins);
    bus.instruction = ins; bus.zero = z; bus.carry = cy; bus.stack_full = full;
    bus.stack_empty = empty; bus.stack_addr = saddr; bus.irq = irq_v; bus.io_ready = 1'b0;
    e = idle(); e.ldpc = 1'b0;
    @(negedge clk); chk({nm, "_fetch"}, sample(), e);
    @(posedge clk); #1;
    @(negedge clk); chk({nm, "_decode"}, sample(), m_decode(ins, empty));
    @(posedge clk); #1;
    w = 0;
    ready = (nlow == 0);
    bus.io_ready = ready;
    @(negedge clk);
    if (is_io(ins)) chk({nm, "_exec"}, sample(), m_io(ins, ready, 1'b0));
    else            chk({nm, "_exec"}, sample(), m_exec(ins, z, cy, full, empty, saddr));
    done = !is_io(ins) || ready;
    while (!done) begin
      @(posedge clk); #1;
      w++;
      if (w == rst_at) begin
        rst = 1'b1;
        @(negedge clk); chk({nm, "_rst_mid_wait"}, sample(), idle());
        @(posedge clk); #1;
        rst = 1'b0;
        ie_m = 1'b0;
        return;
      end
      ready = (w >= nlow);
      bus.io_ready = ready;
      to = !ready && (w == IO_TO);
      @(negedge clk); chk($sformatf("%s_wait%0d", nm, w), sample(), m_io(ins, ready, to));
      done = ready || to;
    end
    if (ins[15:11] == 5'd0) ie_m = ins[0];
    if (ins[15:11] == 5'd1 && !empty) ie_m = 1'b1;
    @(posedge clk); #1;
    if (irq_v && ie_m && !full) begin
      e = idle();
      e.wr_en = 1'b1; e.irq_ack = 1'b1; e.flag_save = 1'b1; e.selpc = 1'b1;
      e.naddress = 11'h004;
      @(negedge clk); chk({nm, "_irq"}, sample(), e);
      ie_m = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] ins;
    int nlow, rat;
    bus.instruction = '0; bus.zero = 0; bus.carry = 0; bus.stack_addr = '0;
    bus.stack_full = 0; bus.stack_empty = 0; bus.io_ready = 0; bus.irq = 1'b1;
    @(negedge clk); chk("reset_outputs", sample(), idle());
    @(posedge clk); #1;
    @(negedge clk); chk("reset_outputs_hold", sample(), idle());
    @(posedge clk); #1;
    rst = 1'b0;

    run({5'd2, 3'd3, 8'h5A}, 0, 0, 0, 0, 0, 0, 11'h0, 0);          // ldi r3,0x5A
    run({5'd3, 3'd1, 8'h21}, 4, 0, 0, 0, 0, 0, 11'h0, 0);          // ldm r1,0x21, 4 low
    run({5'd3, 3'd1, 8'h21}, 1000, 0, 0, 0, 0, 0, 11'h0, 0);       // ldm timeout
    run({5'd4, 3'd5, 8'hC4}, 2, 0, 0, 0, 0, 0, 11'h0, 0);          // stm r5,0xC4
    run(16'h0001, 0, 0, 0, 0, 0, 0, 11'h0, 0);                     // ei
    run({5'd6, 3'd1, 3'd2, 5'd0}, 0, 1, 1, 0, 0, 0, 11'h0, 0);     // add + irq
    run({5'd1, 11'd0}, 0, 0, 0, 1, 0, 0, 11'h2AB, 0);              // reti
    run(16'h0000, 0, 1, 0, 0, 0, 0, 11'h0, 0);                     // di with irq: not taken
    run(16'h0001, 0, 1, 0, 0, 0, 0, 11'h0, 0);                     // ei with irq: taken
    run(16'h0001, 0, 0, 0, 0, 0, 0, 11'h0, 0);
    run({5'd30, 11'd0}, 0, 1, 0, 0, 1, 0, 11'h0, 0);               // irq pending, stack full
    run({5'd16, 11'h100}, 0, 0, 0, 0, 1, 0, 11'h0, 0);             // csr while full
    run({5'd31, 3'd2, 8'h33}, 0, 0, 0, 0, 0, 0, 11'h0, 0);         // ldr r2,0x33
    run({5'd17, 11'd0}, 0, 0, 0, 0, 0, 1, 11'h155, 0);             // ret while empty
    run({5'd3, 3'd6, 8'h10}, 1000, 0, 0, 0, 0, 0, 11'h0, 5);       // reset mid wait
    run({5'd30, 11'd0}, 0, 1, 0, 0, 0, 0, 11'h0, 0);               // ie cleared by reset

    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ins = {5'd0, 10'd0, 1'($urandom_range(0, 1))};
      nlow = $urandom_range(0, 9);
      if (nlow == 9) nlow = 40;
      else if (nlow > 4) nlow = 0;
      rat = (is_io(ins) && nlow > 3 && $urandom_range(0, 7) == 0) ? 2 : 0;
      run(ins, nlow, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          11'($urandom), rat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
